// File: rtl/ex_div_ctrl_if.sv
// ex_div_ctrl_if: request/result bundle between the EX-stage pipeline and the
// iterative divide sequencer.
//   master (pipeline): drives the id_ex_reg_* request fields and flush_i,
//                      observes stall/busy/valid and the result beat.
//   slave  (divider):  the reverse.
//   id_ex_reg_div_req_i   1   divide instruction present in EX
//   id_ex_reg_div_op_i    2   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   id_ex_reg_op_a_i      32  dividend
//   id_ex_reg_op_b_i      32  divisor
//   id_ex_reg_reg_waddr_i 5   destination register
//   flush_i               1   kill the in-flight instruction
//   div_stall_o           1   hold IF/ID/EX registers
//   div_busy_o            1   sequencer is iterating
//   div_valid_o           1   one-cycle result beat
//   div_result_o          32  quotient or remainder
//   div_reg_waddr_o       5   destination of the result beat
interface ex_div_ctrl_if;
    logic        id_ex_reg_div_req_i;
    logic [1:0]  id_ex_reg_div_op_i;
    logic [31:0] id_ex_reg_op_a_i;
    logic [31:0] id_ex_reg_op_b_i;
    logic [4:0]  id_ex_reg_reg_waddr_i;
    logic        flush_i;
    logic        div_stall_o;
    logic        div_busy_o;
    logic        div_valid_o;
    logic [31:0] div_result_o;
    logic [4:0]  div_reg_waddr_o;

    modport master (
        output id_ex_reg_div_req_i,
        output id_ex_reg_div_op_i,
        output id_ex_reg_op_a_i,
        output id_ex_reg_op_b_i,
        output id_ex_reg_reg_waddr_i,
        output flush_i,
        input  div_stall_o,
        input  div_busy_o,
        input  div_valid_o,
        input  div_result_o,
        input  div_reg_waddr_o
    );

    modport slave (
        input  id_ex_reg_div_req_i,
        input  id_ex_reg_div_op_i,
        input  id_ex_reg_op_a_i,
        input  id_ex_reg_op_b_i,
        input  id_ex_reg_reg_waddr_i,
        input  flush_i,
        output div_stall_o,
        output div_busy_o,
        output div_valid_o,
        output div_result_o,
        output div_reg_waddr_o
    );
endinterface

// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: iterative 32-step radix-2 restoring divide sequencer for the
// EX stage (DIV/DIVU/REM/REMU). Stalls the pipeline while iterating and emits
// one result beat together with the destination register address.
// Ports:
//   clk     pipeline clock
//   rst_n   asynchronous active-low reset
//   div_if  ex_div_ctrl_if.slave (request fields, flush, stall/busy/valid,
//           result and destination)
// Optional build macro:
//   DIV_ZERO_FAST_EN  divide-by-zero skips the iteration and finishes in one
//                     cycle with the same result value.
module ex_div_ctrl (
    input  logic          clk,
    input  logic          rst_n,
    ex_div_ctrl_if.slave  div_if
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned RA_W  = 5;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e state_q;
    state_e state_d;

    // Iteration registers: dvd_q collects quotient bits as the dividend shifts out.
    logic [XLEN-1:0]  dvd_q;
    logic [XLEN-1:0]  dvs_q;
    logic [XLEN-1:0]  rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             is_rem_q;
    logic             sign_a_q;
    logic             sign_q_q;
    logic [RA_W-1:0]  waddr_q;

    // Result beat registers.
    logic [XLEN-1:0]  result_q;
    logic [RA_W-1:0]  res_waddr_q;

    // FSM controls.
    logic start_c;
    logic finish_c;
    logic req_go_c;

    // Request decode and operand magnitude.
    logic            is_signed_c;
    logic            a_neg_c;
    logic            b_neg_c;
    logic [XLEN-1:0] abs_a_c;
    logic [XLEN-1:0] abs_b_c;

    // One restoring step.
    logic [XLEN:0]   rem_sh_c;
    logic [XLEN:0]   dvs_ext_c;
    logic            ge_c;
    logic [XLEN-1:0] rem_step_c;
    logic [XLEN-1:0] dvd_step_c;

    // Sign fixup of the final step.
    logic [XLEN-1:0] q_fix_c;
    logic [XLEN-1:0] r_fix_c;
    logic [XLEN-1:0] res_calc_c;

`ifdef DIV_ZERO_FAST_EN
    logic            fast_zero_c;
    logic [XLEN-1:0] zero_res_c;
`endif

    assign req_go_c = div_if.id_ex_reg_div_req_i & ~div_if.flush_i;

    // Operand magnitudes: DIV/REM (op[0] == 0) are signed.
    always_comb begin
        is_signed_c = ~div_if.id_ex_reg_div_op_i[0];
        a_neg_c     = is_signed_c & div_if.id_ex_reg_op_a_i[XLEN-1];
        b_neg_c     = is_signed_c & div_if.id_ex_reg_op_b_i[XLEN-1];
        abs_a_c     = a_neg_c ? (~div_if.id_ex_reg_op_a_i + XLEN'(1))
                              : div_if.id_ex_reg_op_a_i;
        abs_b_c     = b_neg_c ? (~div_if.id_ex_reg_op_b_i + XLEN'(1))
                              : div_if.id_ex_reg_op_b_i;
    end

    // Restoring step; the compare is 33 bits wide so a full-range divisor works.
    always_comb begin
        rem_sh_c   = {rem_q, dvd_q[XLEN-1]};
        dvs_ext_c  = {1'b0, dvs_q};
        ge_c       = (rem_sh_c >= dvs_ext_c);
        rem_step_c = ge_c ? XLEN'(rem_sh_c - dvs_ext_c) : rem_sh_c[XLEN-1:0];
        dvd_step_c = {dvd_q[XLEN-2:0], ge_c};
    end

    // Divide-by-zero needs no special case: the quotient saturates to all ones
    // and is left unnegated, the remainder equals the dividend.
    always_comb begin
        q_fix_c    = (sign_q_q && (dvs_q != '0)) ? (~dvd_step_c + XLEN'(1)) : dvd_step_c;
        r_fix_c    = sign_a_q ? (~rem_step_c + XLEN'(1)) : rem_step_c;
        res_calc_c = is_rem_q ? r_fix_c : q_fix_c;
    end

`ifdef DIV_ZERO_FAST_EN
    assign zero_res_c = div_if.id_ex_reg_div_op_i[1] ? div_if.id_ex_reg_op_a_i : '1;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and step controls.
    always_comb begin
        state_d  = state_q;
        start_c  = 1'b0;
        finish_c = 1'b0;
`ifdef DIV_ZERO_FAST_EN
        fast_zero_c = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_go_c) begin
                    start_c = 1'b1;
                    state_d = S_CALC;
`ifdef DIV_ZERO_FAST_EN
                    if (div_if.id_ex_reg_op_b_i == '0) begin
                        fast_zero_c = 1'b1;
                        state_d     = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                if (div_if.flush_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == LAST_STEP) begin
                    finish_c = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                // A req still high here belongs to the finished instruction.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand capture, iteration and result registration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            is_rem_q    <= 1'b0;
            sign_a_q    <= 1'b0;
            sign_q_q    <= 1'b0;
            waddr_q     <= '0;
            result_q    <= '0;
            res_waddr_q <= '0;
        end else begin
            if (start_c) begin
                dvd_q    <= abs_a_c;
                dvs_q    <= abs_b_c;
                rem_q    <= '0;
                cnt_q    <= '0;
                is_rem_q <= div_if.id_ex_reg_div_op_i[1];
                sign_a_q <= a_neg_c;
                sign_q_q <= is_signed_c & (div_if.id_ex_reg_op_a_i[XLEN-1]
                                         ^ div_if.id_ex_reg_op_b_i[XLEN-1]);
                waddr_q  <= div_if.id_ex_reg_reg_waddr_i;
            end else if (state_q == S_CALC) begin
                rem_q <= rem_step_c;
                dvd_q <= dvd_step_c;
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (finish_c) begin
                result_q    <= res_calc_c;
                res_waddr_q <= waddr_q;
            end
`ifdef DIV_ZERO_FAST_EN
            if (fast_zero_c) begin
                result_q    <= zero_res_c;
                res_waddr_q <= div_if.id_ex_reg_reg_waddr_i;
            end
`endif
        end
    end

    // Stall drops combinationally on flush so the pipeline can refetch at once.
    assign div_if.div_stall_o = rst_n & (((state_q == S_IDLE) & req_go_c)
                                       | ((state_q == S_CALC) & ~div_if.flush_i));
    assign div_if.div_busy_o      = (state_q == S_CALC);
    assign div_if.div_valid_o     = (state_q == S_DONE) & ~div_if.flush_i;
    assign div_if.div_result_o    = result_q;
    assign div_if.div_reg_waddr_o = res_waddr_q;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb_ex_div_ctrl: self-checking bench for ex_div_ctrl with a scoreboard queue
// of expected result beats, pushed at issue and popped at the valid beat.
module tb_ex_div_ctrl;
    localparam int CALC_LAT = 33;
`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST_ZERO = 1'b1;
`else
    localparam bit FAST_ZERO = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  wa;
    } exp_t;

    logic clk;
    logic rst_n;
    ex_div_ctrl_if dif();

    ex_div_ctrl u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_if (dif)
    );

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles from the request cycle T to the valid beat.
    function automatic int exp_lat(input logic [31:0] b);
        return (FAST_ZERO && (b == 32'd0)) ? 1 : CALC_LAT;
    endfunction

    // Reference behaviour of the RISC-V M divide instructions.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'd0:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            2'd1:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'd2:    return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Present a request one step after a rising edge; reports stall in cycle T.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa, input logic [31:0] exp_res,
                         output logic stall0);
        exp_t e;
        @(posedge clk);
        #1;
        dif.id_ex_reg_div_req_i   = 1'b1;
        dif.id_ex_reg_div_op_i    = op;
        dif.id_ex_reg_op_a_i      = a;
        dif.id_ex_reg_op_b_i      = b;
        dif.id_ex_reg_reg_waddr_i = wa;
        e.res = exp_res;
        e.wa  = wa;
        sb_q.push_back(e);
        @(negedge clk);
        stall0 = dif.div_stall_o;
    endtask

    // Wait (bounded) for the valid beat; lat stays -1 on timeout.
    task automatic collect(output int lat, output int stall_cnt, output logic stall_at_valid,
                           output logic [31:0] res, output logic [4:0] wa);
        lat = -1;
        stall_cnt = 0;
        stall_at_valid = 1'bx;
        res = 32'hDEAD_BEEF;
        wa = 5'h1F;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (dif.div_valid_o) begin
                lat = c;
                stall_at_valid = dif.div_stall_o;
                res = dif.div_result_o;
                wa = dif.div_reg_waddr_o;
                break;
            end
            if (dif.div_stall_o && dif.div_busy_o) stall_cnt++;
        end
    endtask

    task automatic drop_req();
        @(posedge clk);
        #1;
        dif.id_ex_reg_div_req_i = 1'b0;
    endtask

    task automatic test_reset();
        dif.id_ex_reg_div_req_i   = 1'b1;
        dif.id_ex_reg_div_op_i    = 2'd0;
        dif.id_ex_reg_op_a_i      = 32'd9;
        dif.id_ex_reg_op_b_i      = 32'd3;
        dif.id_ex_reg_reg_waddr_i = 5'd1;
        dif.flush_i               = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({dif.div_stall_o, dif.div_busy_o, dif.div_valid_o, dif.div_result_o,
             dif.div_reg_waddr_o} !== 40'd0)
            $display("FAIL reset_outputs: got stall=%b busy=%b valid=%b res=%h wa=%h, want all 0",
                     dif.div_stall_o, dif.div_busy_o, dif.div_valid_o, dif.div_result_o,
                     dif.div_reg_waddr_o);
        else n_pass++;
        dif.id_ex_reg_div_req_i = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({dif.div_stall_o, dif.div_busy_o, dif.div_valid_o} !== 3'b000)
            $display("FAIL post_reset_idle: got stall=%b busy=%b valid=%b, want 000",
                     dif.div_stall_o, dif.div_busy_o, dif.div_valid_o);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [1:0]  ops [8] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd2};
        logic [31:0] as  [8] = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'd100, 32'd100};
        logic [31:0] bs  [8] = '{32'd7, 32'd2, 32'h10, 32'h10, 32'd7, 32'd7,
                                 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] xs  [8] = '{32'd14, 32'hFFFF_FFFF, 32'h0FFF_FFFF, 32'hF,
                                 32'hFFFF_FFF2, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 32'd2};
        logic s0, sv;
        int lat, sc;
        logic [31:0] r;
        logic [4:0] w;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], as[i], bs[i], 5'(i + 3), xs[i], s0);
            collect(lat, sc, sv, r, w);
            e = sb_q.pop_front();
            n_checks++;
            if (r !== e.res) $display("FAIL basic_res[%0d]: got %h want %h", i, r, e.res);
            else n_pass++;
            n_checks++;
            if (w !== e.wa) $display("FAIL basic_waddr[%0d]: got %0d want %0d", i, w, e.wa);
            else n_pass++;
            n_checks++;
            if (lat !== CALC_LAT) $display("FAIL basic_lat[%0d]: got %0d want %0d", i, lat, CALC_LAT);
            else n_pass++;
            n_checks++;
            if ({s0, sv} !== 2'b10)
                $display("FAIL basic_stall_edges[%0d]: got T=%b valid=%b want 1,0", i, s0, sv);
            else n_pass++;
            n_checks++;
            if (sc !== CALC_LAT - 1)
                $display("FAIL basic_stall_cnt[%0d]: got %0d want %0d", i, sc, CALC_LAT - 1);
            else n_pass++;
            drop_req();
        end
        @(negedge clk);
        n_checks++;
        if ({dif.div_stall_o, dif.div_busy_o, dif.div_valid_o} !== 3'b000)
            $display("FAIL basic_idle_after: got stall=%b busy=%b valid=%b want 000",
                     dif.div_stall_o, dif.div_busy_o, dif.div_valid_o);
        else n_pass++;
    endtask

    task automatic test_div_zero();
        logic [1:0]  ops [4] = '{2'd1, 2'd2, 2'd0, 2'd3};
        logic [31:0] as  [4] = '{32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd5};
        logic [31:0] xs  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'd5};
        logic s0, sv;
        int lat, sc;
        logic [31:0] r;
        logic [4:0] w;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], 32'd0, 5'(i + 11), xs[i], s0);
            collect(lat, sc, sv, r, w);
            e = sb_q.pop_front();
            n_checks++;
            if (r !== e.res) $display("FAIL dz_res[%0d]: got %h want %h", i, r, e.res);
            else n_pass++;
            n_checks++;
            if (w !== e.wa) $display("FAIL dz_waddr[%0d]: got %0d want %0d", i, w, e.wa);
            else n_pass++;
            n_checks++;
            if (lat !== exp_lat(32'd0))
                $display("FAIL dz_lat[%0d]: got %0d want %0d", i, lat, exp_lat(32'd0));
            else n_pass++;
            n_checks++;
            if ({s0, sv, 32'(sc)} !== {2'b10, 32'(exp_lat(32'd0) - 1)})
                $display("FAIL dz_stall[%0d]: got T=%b valid=%b cnt=%0d want 1,0,%0d",
                         i, s0, sv, sc, exp_lat(32'd0) - 1);
            else n_pass++;
            drop_req();
        end
    endtask

    task automatic test_overflow();
        logic s0, sv;
        int lat, sc;
        logic [31:0] r;
        logic [4:0] w;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            issue((i == 0) ? 2'd0 : 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'(i + 15),
                  (i == 0) ? 32'h8000_0000 : 32'd0, s0);
            collect(lat, sc, sv, r, w);
            e = sb_q.pop_front();
            n_checks++;
            if (r !== e.res) $display("FAIL ovf_res[%0d]: got %h want %h", i, r, e.res);
            else n_pass++;
            n_checks++;
            if ({w, 32'(lat)} !== {e.wa, 32'(CALC_LAT)})
                $display("FAIL ovf_waddr_lat[%0d]: got %0d/%0d want %0d/%0d",
                         i, w, lat, e.wa, CALC_LAT);
            else n_pass++;
            drop_req();
        end
    endtask

    // Consecutive requests with no idle gap: each new one is presented at T+34.
    task automatic test_back_to_back();
        logic s0, sv;
        int lat, sc;
        logic [31:0] r, a, b;
        logic [1:0] op;
        logic [4:0] w;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            if (i % 4 == 1) b = {16'hFFFF, b[15:0]};
            issue(op, a, b, 5'($urandom_range(0, 31)), model(op, a, b), s0);
            collect(lat, sc, sv, r, w);
            e = sb_q.pop_front();
            n_checks++;
            if (r !== e.res)
                $display("FAIL b2b_res[%0d]: op=%0d a=%h b=%h got %h want %h", i, op, a, b, r, e.res);
            else n_pass++;
            n_checks++;
            if ({w, 32'(lat)} !== {e.wa, 32'(exp_lat(b))})
                $display("FAIL b2b_waddr_lat[%0d]: got %0d/%0d want %0d/%0d",
                         i, w, lat, e.wa, exp_lat(b));
            else n_pass++;
        end
        drop_req();
    endtask

    task automatic test_flush_calc();
        logic s0, sv;
        int lat, sc;
        logic [31:0] r;
        logic [4:0] w;
        exp_t e;
        issue(2'd0, 32'd1000, 32'd3, 5'd20, 32'd333, s0);
        void'(sb_q.pop_back());
        repeat (10) @(posedge clk);
        #1;
        dif.flush_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({dif.div_stall_o, dif.div_busy_o, dif.div_valid_o} !== 3'b010)
            $display("FAIL flush_calc_t10: got stall=%b busy=%b valid=%b want 0,1,0",
                     dif.div_stall_o, dif.div_busy_o, dif.div_valid_o);
        else n_pass++;
        @(posedge clk);
        #1;
        dif.flush_i = 1'b0;
        dif.id_ex_reg_div_req_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({dif.div_stall_o, dif.div_busy_o, dif.div_valid_o} !== 3'b000)
            $display("FAIL flush_calc_t11: got stall=%b busy=%b valid=%b want 000",
                     dif.div_stall_o, dif.div_busy_o, dif.div_valid_o);
        else n_pass++;
        issue(2'd0, 32'd1000, 32'd3, 5'd21, 32'd333, s0);
        collect(lat, sc, sv, r, w);
        e = sb_q.pop_front();
        n_checks++;
        if ({r, w, 32'(lat)} !== {e.res, e.wa, 32'(CALC_LAT)})
            $display("FAIL flush_restart: got res=%h wa=%0d lat=%0d want %h/%0d/%0d",
                     r, w, lat, e.res, e.wa, CALC_LAT);
        else n_pass++;
        drop_req();
    endtask

    task automatic test_flush_done();
        logic s0;
        exp_t e;
        issue(2'd0, 32'd50, 32'd5, 5'd22, 32'd10, s0);
        e = sb_q.pop_front();
        repeat (CALC_LAT) @(posedge clk);
        #1;
        dif.flush_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({dif.div_stall_o, dif.div_busy_o, dif.div_valid_o} !== 3'b000)
            $display("FAIL flush_done_valid: got stall=%b busy=%b valid=%b want 000",
                     dif.div_stall_o, dif.div_busy_o, dif.div_valid_o);
        else n_pass++;
        n_checks++;
        if ({dif.div_result_o, dif.div_reg_waddr_o} !== {e.res, e.wa})
            $display("FAIL flush_done_regs: got %h/%0d want %h/%0d",
                     dif.div_result_o, dif.div_reg_waddr_o, e.res, e.wa);
        else n_pass++;
        @(posedge clk);
        #1;
        dif.flush_i = 1'b0;
        dif.id_ex_reg_div_req_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic s0, sv;
        int lat, sc;
        logic [31:0] r;
        logic [4:0] w;
        exp_t e;
        issue(2'd0, 32'd77777, 32'd7, 5'd23, 32'd11111, s0);
        void'(sb_q.pop_back());
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({dif.div_stall_o, dif.div_busy_o, dif.div_valid_o, dif.div_result_o,
             dif.div_reg_waddr_o} !== 40'd0)
            $display("FAIL reset_mid: got stall=%b busy=%b valid=%b res=%h wa=%h, want all 0",
                     dif.div_stall_o, dif.div_busy_o, dif.div_valid_o, dif.div_result_o,
                     dif.div_reg_waddr_o);
        else n_pass++;
        dif.id_ex_reg_div_req_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(2'd0, 32'd9, 32'd3, 5'd24, 32'd3, s0);
        collect(lat, sc, sv, r, w);
        e = sb_q.pop_front();
        n_checks++;
        if ({r, w, 32'(lat)} !== {e.res, e.wa, 32'(CALC_LAT)})
            $display("FAIL reset_restart: got res=%h wa=%0d lat=%0d want %h/%0d/%0d",
                     r, w, lat, e.res, e.wa, CALC_LAT);
        else n_pass++;
        drop_req();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_flush_calc();
        test_flush_done();
        test_reset_mid();
        n_checks++;
        if (sb_q.size() !== 0) $display("FAIL scoreboard_empty: got %0d entries want 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ex_div_ctrl.md
# ex_div_ctrl

Iterative divide sequencer for the EX stage. It accepts DIV/DIVU/REM/REMU requests decoded into id_ex_reg and runs a 32-step radix-2 restoring division on private registers. While it runs, it holds the pipeline with a stall. It delivers one result beat toward ex_mem_reg together with the destination register address.

## Interface
- No parameters; width fixed at 32.
- clk  in  1  pipeline clock
- rst_n  in  1  reset, asynchronous, active-low
- id_ex_reg_div_req_i  in  1  divide instruction present in EX; held by the pipeline while stalled
- id_ex_reg_div_op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- id_ex_reg_op_a_i  in  32  dividend
- id_ex_reg_op_b_i  in  32  divisor
- id_ex_reg_reg_waddr_i  in  5  destination register
- flush_i  in  1  kill the in-flight instruction (branch/flush)
- div_stall_o  out  1  hold IF/ID/EX registers
- div_busy_o  out  1  state is CALC
- div_valid_o  out  1  one-cycle result beat
- div_result_o  out  32  quotient or remainder
- div_reg_waddr_o  out  5  destination captured at start

## Operation
- States: IDLE, CALC, DONE.
- IDLE → CALC when div_req & !flush_i.
  - Latch |a| and |b|; signed ops take two's-complement abs, unsigned ops pass through.
  - Latch op, waddr, sign_a, and sign_q = sign_a ^ sign_b.
  - Clear the 32-bit partial remainder; count = 0.
- CALC, one step per cycle:
  - rem' = {rem[30:0], dvd[31]}; dvd shifts left.
  - If rem' >= divisor (33-bit compare): subtract the divisor and shift in quotient bit 1; otherwise shift in 0.
  - count increments. After step 31 (count == 31), go to DONE.
- DONE: one cycle, then IDLE.
  - div_valid_o = 1 unless flush_i.
  - div_result_o is registered at the CALC→DONE transition.
- Sign fixup at CALC→DONE:
  - Quotient is negated iff signed op & sign_q & divisor != 0.
  - Remainder is negated iff signed op & sign_a.
- Divide-by-zero: quotient = 0xFFFFFFFF, remainder = dividend. This falls out of the algorithm plus the fixup rule.
- Overflow 0x80000000 / 0xFFFFFFFF (signed): quotient 0x80000000, remainder 0. No special case is needed.
- Stall: div_stall_o = (IDLE & div_req & !flush_i) | CALC. Stall is 0 in DONE so the pipeline advances and ex_mem_reg samples the result.
- A req still high in DONE is the finished instruction and is ignored.
- A req in the next IDLE cycle starts a new division.
- flush_i in CALC aborts to IDLE: no valid beat, stall drops the same cycle (combinational).
- flush_i in DONE suppresses div_valid_o.
- Reset (any state, async) → IDLE. Outputs: div_valid_o 0, div_result_o 0, div_reg_waddr_o 0, div_busy_o 0, div_stall_o 0.
  - div_stall_o is 0 because the state is IDLE; stall is gated by rst_n.

## Timing
- T: req seen in IDLE, stall = 1.
- T+1..T+32: CALC, 32 cycles, stall = 1, busy = 1.
- T+33: DONE, valid = 1, stall = 0; ex_mem_reg captures at the T+33 edge.
- The instruction occupies EX for 34 cycles.
- Back-to-back divides: the second starts at T+34 (IDLE sees req).
- div_result_o and div_reg_waddr_o hold their values until the next CALC→DONE transition.

## Configuration
- DIV_ZERO_FAST_EN:
  - Defined: in IDLE with div_req & divisor == 0, go directly to DONE. The result is the divide-by-zero value (0xFFFFFFFF or the dividend). Stall is 1 for cycle T only; valid at T+1.
  - Undefined: divide-by-zero runs the full 32 steps with identical results.

## Test plan
- DIV 100 / 7 → div_valid_o at T+33 with result 14, stall high for exactly T..T+32, waddr echoed.
- REM 0xFFFFFFF9 (−7) % 2 → 0xFFFFFFFF; DIVU 0xFFFFFFFF / 0x10 → 0x0FFFFFFF; REMU same operands → 0xF.
- DIVU 5 / 0 → 0xFFFFFFFF; REM 0xFFFFFFFB / 0 → 0xFFFFFFFB; with DIV_ZERO_FAST_EN, valid at T+1.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0.
- flush_i at T+10 → IDLE at T+11, div_valid_o never asserts, stall 0 from T+10. A new req at T+12 completes normally at T+45.
- rst_n low at T+20 → all outputs 0 immediately. After release, a new DIV 9 / 3 → 3.
